// File: rtl/sid_pot.sv
// sid_pot: SID POTX/POTY A/D emulation, times RC charge of two pot inputs
//   clk        in   system clock
//   res_n      in   asynchronous active-low reset
//   phi2_tick  in   1-clk strobe per phi2 cycle; all counting is paced by it
//   pot_cmp    in   [0]=X, [1]=Y async comparators, 1 = cap above threshold
//   pot_dis    out  1 = discharge pot caps to ground
//   pot_x      out  last completed X measurement
//   pot_y      out  last completed Y measurement
//   pot_done   out  1-clk pulse when pot_x/pot_y update
module sid_pot #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       phi2_tick,
   input  logic [1:0] pot_cmp,
   output logic       pot_dis,
   output logic [7:0] pot_x,
   output logic [7:0] pot_y,
   output logic       pot_done
);
   typedef enum logic {DISCHARGE, CHARGE} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0][1:0] sync_q;
   logic [1:0] cmp_s, trip, trip_n;
   logic [7:0] cnt, cnt_n;
   logic [1:0][7:0] cap, cap_n;
   logic fin, fin_n;
   assign cmp_s   = sync_q[SYNC_STAGES-1];
   assign pot_dis = (state == DISCHARGE);
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pot_cmp};
   end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      trip_n  = trip;
      cap_n   = cap;
      fin_n   = 1'b0;
      if (phi2_tick) begin
         cnt_n = cnt + 8'd1;
         if (state == DISCHARGE) begin
            if (cnt == 8'hff) begin
               state_n = CHARGE;
               trip_n  = '0;
            end
         end else begin
            for (int i = 0; i < 2; i++)
               if (!trip[i] && cmp_s[i]) begin
                  cap_n[i]  = cnt;
                  trip_n[i] = 1'b1;
               end
            if (cnt == 8'hff) begin
               // sampling above has already run, so only truly untripped channels saturate
               for (int i = 0; i < 2; i++)
                  if (!trip_n[i]) cap_n[i] = 8'hff;
               state_n = DISCHARGE;
               fin_n   = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state    <= DISCHARGE;
         cnt      <= '0;
         trip     <= '0;
         cap      <= '0;
         fin      <= 1'b0;
         pot_x    <= '0;
         pot_y    <= '0;
         pot_done <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         trip     <= trip_n;
         cap      <= cap_n;
         fin      <= fin_n;
         pot_done <= fin;
         // both outputs load from the final captures together, one clk after the last tick
         if (fin) begin
            pot_x <= cap[0];
            pot_y <= cap[1];
         end
      end
   end
endmodule

// File: tb/tb_sid_pot.sv
// tb_sid_pot: directed self-checking bench for sid_pot
module tb_sid_pot;
   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic       phi2_tick = 1'b0;
   logic [1:0] pot_cmp = 2'b00;
   logic       pot_dis;
   logic [7:0] pot_x, pot_y;
   logic       pot_done;
   int n_chk = 0;
   int n_fail = 0;
   sid_pot #(.SYNC_STAGES(2)) dut (
      .clk(clk), .res_n(res_n), .phi2_tick(phi2_tick), .pot_cmp(pot_cmp),
      .pot_dis(pot_dis), .pot_x(pot_x), .pot_y(pot_y), .pot_done(pot_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   // comparator level before global tick t; trip=-1 never high, -2 always high,
   // else rises so the synchronized level is first sampled at charge cnt==trip
   function automatic logic lvl(input int trip, input int t, input int lead, input bit glitch);
      int tt;
      logic on;
      if (trip == -1) return 1'b0;
      if (trip == -2) return 1'b1;
      tt = 257 + trip;
      on = (t > tt - lead);
      if (glitch && t > tt + 5 && t <= tt + 15) on = 1'b0;
      return on;
   endfunction
   task automatic tick(input int gap);
      repeat (gap - 1) @(negedge clk);
      phi2_tick = 1'b1;
      @(negedge clk);
      phi2_tick = 1'b0;
   endtask
   task automatic run_meas(input int gap, input int tx, input int ty, input bit glitch, input int nticks);
      int lead;
      lead = (gap >= 3) ? 1 : 3;
      for (int t = 1; t <= nticks; t++) begin
         pot_cmp[0] = lvl(tx, t, lead, glitch);
         pot_cmp[1] = lvl(ty, t, lead, 1'b0);
         chk("pot_dis", int'(pot_dis), (t <= 256) ? 1 : 0);
         chk("pot_done_early", int'(pot_done), 0);
         tick(gap);
      end
   endtask
   task automatic result(input string tag, input int ex, input int ey);
      @(negedge clk);
      chk({tag, "_done"}, int'(pot_done), 1);
      chk({tag, "_x"}, int'(pot_x), ex);
      chk({tag, "_y"}, int'(pot_y), ey);
      @(negedge clk);
      chk({tag, "_done_clr"}, int'(pot_done), 0);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_dis", int'(pot_dis), 1);
      chk("rst_x", int'(pot_x), 0);
      chk("rst_y", int'(pot_y), 0);
      chk("rst_done", int'(pot_done), 0);
      res_n = 1'b1;
      pot_cmp = 2'b11;
      repeat (10) @(negedge clk);
      chk("idle_dis", int'(pot_dis), 1);
      chk("idle_x", int'(pot_x), 0);
      chk("idle_done", int'(pot_done), 0);
      run_meas(4, 100, 37, 1'b0, 512);
      result("xy_100_37", 100, 37);
      run_meas(4, -1, -1, 1'b0, 512);
      result("never", 255, 255);
      run_meas(4, -2, -2, 1'b0, 512);
      result("always", 0, 0);
      run_meas(4, 50, -1, 1'b1, 512);
      result("glitch", 50, 255);
      run_meas(4, 77, 77, 1'b0, 512);
      result("same_tick", 77, 77);
      run_meas(4, 255, 0, 1'b0, 512);
      result("edges", 255, 0);
      run_meas(4, 30, 40, 1'b0, 256 + 81);
      #1 res_n = 1'b0;
      #1;
      chk("abort_dis", int'(pot_dis), 1);
      chk("abort_x", int'(pot_x), 0);
      chk("abort_y", int'(pot_y), 0);
      chk("abort_done", int'(pot_done), 0);
      pot_cmp = 2'b00;
      @(negedge clk);
      res_n = 1'b1;
      run_meas(4, 10, 20, 1'b0, 512);
      result("after_abort", 10, 20);
      run_meas(1, 200, -1, 1'b0, 512);
      result("gap1", 200, 255);
      run_meas(3, 200, -1, 1'b0, 512);
      result("gap3", 200, 255);
      run_meas(17, 200, -1, 1'b0, 512);
      result("gap17", 200, 255);
      pot_cmp = 2'b01;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("notick_done", int'(pot_done), 0);
      end
      chk("notick_x", int'(pot_x), 200);
      chk("notick_dis", int'(pot_dis), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
